// File: rtl/dm_pkg.sv
// Shared Debug Module definitions: DMI register map, sbcs field layout,
// sberror codes and the System Bus Access FSM encoding.
package dm_pkg;

  localparam logic [6:0] DMI_SBCS       = 7'h38;
  localparam logic [6:0] DMI_SBADDRESS0 = 7'h39;
  localparam logic [6:0] DMI_SBDATA0    = 7'h3C;

  localparam int SBCS_BUSYERROR  = 22;
  localparam int SBCS_READONADDR = 20;
  localparam int SBCS_ACCESS_LSB = 17;
  localparam int SBCS_AUTOINC    = 16;
  localparam int SBCS_READONDATA = 15;
  localparam int SBCS_ERROR_LSB  = 12;

  localparam logic [2:0] SBERR_NONE    = 3'd0;
  localparam logic [2:0] SBERR_TIMEOUT = 3'd1;
  localparam logic [2:0] SBERR_BADADDR = 3'd2;
  localparam logic [2:0] SBERR_ALIGN   = 3'd3;
  localparam logic [2:0] SBERR_SIZE    = 3'd4;

  localparam logic [2:0] SBVERSION   = 3'd1;
  localparam logic [2:0] SBACCESS_32 = 3'd2;

  typedef enum logic {
    SBA_IDLE,
    SBA_REQ
  } sba_state_e;

  // True when the low address bits are not a multiple of the access size.
  function automatic logic sba_misaligned(input logic [2:0] size, input logic [1:0] lo);
    return ((size == 3'd1) && lo[0]) || ((size == 3'd2) && (lo != 2'b00));
  endfunction

endpackage

// File: rtl/sba_lane_align.sv
// Maps an access size and byte offset onto the 32-bit bus lanes: byte enables,
// write-data replication and zero-extended extraction of read data.
module sba_lane_align
  import dm_pkg::*;
(
  input  logic [2:0]  size_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [31:0] shifted;

  always_comb begin
    shifted = rdata_i >> {off_i, 3'b000};
    be_o    = 4'b1111;
    wdata_o = wdata_i;
    rdata_o = shifted;
    case (size_i)
      3'd0: begin
        be_o    = 4'b0001 << off_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = {24'h0, shifted[7:0]};
      end
      3'd1: begin
        be_o    = 4'b0011 << off_i;
        wdata_o = {2{wdata_i[15:0]}};
        rdata_o = {16'h0, shifted[15:0]};
      end
      default: begin
        be_o    = 4'b1111 << off_i;
        wdata_o = wdata_i;
        rdata_o = shifted;
      end
    endcase
  end

endmodule

// File: rtl/dm_sba_initiator.sv
// System Bus Access engine: sbcs/sbaddress0/sbdata0 behind the DMI, issuing
// single read/write transactions as bus initiator with a bounded ack wait.
module dm_sba_initiator
  import dm_pkg::*;
#(
  parameter int TimeoutCycles = 256,
  parameter int XLEN          = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  dmi_addr,
  input  logic [31:0] dmi_wdata,
  input  logic        dmi_write,
  input  logic        dmi_read,
  output logic        dmi_hit,
  output logic [31:0] dmi_rdata,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_byteenable,
  output logic        bus_read,
  output logic        bus_write,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  input  logic        bus_err
);

  localparam int CW = $clog2(TimeoutCycles) + 1;

  sba_state_e  state_q;
  logic        sbbusyerror_q, sbreadonaddr_q, sbautoincrement_q, sbreadondata_q;
  logic [2:0]  sbaccess_q, sberror_q, req_size_q;
  logic [31:0] sbaddress_q, sbdata_q, req_addr_q, dmi_rdata_q;
  logic        bus_read_q, bus_write_q;
  logic [CW-1:0] cnt_q;

  logic        busy, hit_sbcs, hit_addr, hit_data;
  logic [31:0] sbcs_val, rdata_ext;

  assign busy     = (state_q == SBA_REQ);
  assign hit_sbcs = (dmi_addr == DMI_SBCS);
  assign hit_addr = (dmi_addr == DMI_SBADDRESS0);
  assign hit_data = (dmi_addr == DMI_SBDATA0);
  assign dmi_hit  = hit_sbcs | hit_addr | hit_data;

  assign sbcs_val = {SBVERSION, 6'h0, sbbusyerror_q, busy, sbreadonaddr_q, sbaccess_q,
                     sbautoincrement_q, sbreadondata_q, sberror_q, 7'(XLEN), 5'b00111};

  // Start decode; a start on an sbaddress0 write checks the newly written address.
  logic        can_start, start_rd, start_wr;
  logic [31:0] start_addr;

  always_comb begin
    can_start  = !busy && (sberror_q == SBERR_NONE) && !sbbusyerror_q;
    start_rd   = 1'b0;
    start_wr   = 1'b0;
    start_addr = sbaddress_q;
    if (can_start) begin
      if (dmi_write && hit_addr) begin
        start_addr = dmi_wdata;
        start_rd   = sbreadonaddr_q;
      end else if (dmi_write && hit_data) begin
        start_wr = 1'b1;
      end else if (dmi_read && hit_data) begin
        start_rd = sbreadondata_q;
      end
    end
  end

  sba_lane_align u_lane (
    .size_i  (req_size_q),
    .off_i   (req_addr_q[1:0]),
    .wdata_i (sbdata_q),
    .rdata_i (bus_rdata),
    .be_o    (bus_byteenable),
    .wdata_o (bus_wdata),
    .rdata_o (rdata_ext)
  );

  assign bus_addr  = {req_addr_q[31:2], 2'b00};
  assign bus_read  = bus_read_q;
  assign bus_write = bus_write_q;
  assign dmi_rdata = dmi_rdata_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q           <= SBA_IDLE;
      sbbusyerror_q     <= 1'b0;
      sbreadonaddr_q    <= 1'b0;
      sbautoincrement_q <= 1'b0;
      sbreadondata_q    <= 1'b0;
      sbaccess_q        <= SBACCESS_32;
      sberror_q         <= SBERR_NONE;
      req_size_q        <= SBACCESS_32;
      sbaddress_q       <= '0;
      sbdata_q          <= '0;
      req_addr_q        <= '0;
      dmi_rdata_q       <= '0;
      bus_read_q        <= 1'b0;
      bus_write_q       <= 1'b0;
      cnt_q             <= '0;
    end else begin
      if (dmi_read) begin
        if (hit_sbcs)      dmi_rdata_q <= sbcs_val;
        else if (hit_addr) dmi_rdata_q <= sbaddress_q;
        else if (hit_data) dmi_rdata_q <= sbdata_q;
        else               dmi_rdata_q <= '0;
      end
      if (dmi_write && hit_sbcs) begin
        if (dmi_wdata[SBCS_BUSYERROR]) sbbusyerror_q <= 1'b0;
        sbreadonaddr_q    <= dmi_wdata[SBCS_READONADDR];
        sbaccess_q        <= dmi_wdata[SBCS_ACCESS_LSB +: 3];
        sbautoincrement_q <= dmi_wdata[SBCS_AUTOINC];
        sbreadondata_q    <= dmi_wdata[SBCS_READONDATA];
        sberror_q         <= sberror_q & ~dmi_wdata[SBCS_ERROR_LSB +: 3];
      end
      if (busy && (dmi_read || dmi_write) && (hit_addr || hit_data)) sbbusyerror_q <= 1'b1;
      if (!busy && dmi_write && hit_addr) sbaddress_q <= dmi_wdata;
      if (!busy && dmi_write && hit_data) sbdata_q <= dmi_wdata;

      // Completion assignments come last so a same-cycle error set beats W1C.
      case (state_q)
        SBA_IDLE: begin
          if (start_rd || start_wr) begin
            if (sbaccess_q > SBACCESS_32) begin
              sberror_q <= SBERR_SIZE;
            end else if (sba_misaligned(sbaccess_q, start_addr[1:0])) begin
              sberror_q <= SBERR_ALIGN;
            end else begin
              state_q     <= SBA_REQ;
              bus_read_q  <= start_rd;
              bus_write_q <= start_wr;
              req_addr_q  <= start_addr;
              req_size_q  <= sbaccess_q;
              cnt_q       <= '0;
            end
          end
        end
        SBA_REQ: begin
          if (bus_ack) begin
            state_q     <= SBA_IDLE;
            bus_read_q  <= 1'b0;
            bus_write_q <= 1'b0;
            if (bus_err) begin
              sberror_q <= SBERR_BADADDR;
            end else begin
              if (bus_read_q) sbdata_q <= rdata_ext;
              if (sbautoincrement_q) sbaddress_q <= req_addr_q + (32'd1 << req_size_q);
            end
          end else if (cnt_q == CW'(TimeoutCycles - 1)) begin
            state_q     <= SBA_IDLE;
            bus_read_q  <= 1'b0;
            bus_write_q <= 1'b0;
            sberror_q   <= SBERR_TIMEOUT;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= SBA_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_sba_initiator.sv
// Directed bench for dm_sba_initiator: DMI reads and bus transactions are
// checked by monitors against expected queues filled by the stimulus.
module tb_dm_sba_initiator;

  localparam int BW = 78;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  dmi_addr;
  logic [31:0] dmi_wdata;
  logic        dmi_write, dmi_read, dmi_hit;
  logic [31:0] dmi_rdata;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_byteenable;
  logic        bus_read, bus_write, bus_ack, bus_err;

  logic [31:0]   exp_q[$];
  logic [BW-1:0] bus_q[$];
  logic [31:0]   mem [0:15];
  int            ack_at;
  logic          resp_err;
  int            n_chk = 0;
  int            n_pass = 0;

  dm_sba_initiator #(.TimeoutCycles(8), .XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .dmi_addr(dmi_addr), .dmi_wdata(dmi_wdata), .dmi_write(dmi_write), .dmi_read(dmi_read),
    .dmi_hit(dmi_hit), .dmi_rdata(dmi_rdata),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_byteenable(bus_byteenable),
    .bus_read(bus_read), .bus_write(bus_write),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack), .bus_err(bus_err)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [BW-1:0] mk_bus(input logic rd, input logic wr, input logic [31:0] a,
                                           input logic [3:0] be, input logic [31:0] wd,
                                           input logic [7:0] len);
    return {rd, wr, a, be, (rd ? 32'h0 : wd), len};
  endfunction

  // driver tasks: called at a negedge, return at the following negedge
  task automatic dmi_wr(input logic [6:0] a, input logic [31:0] d);
    dmi_addr = a; dmi_wdata = d; dmi_write = 1'b1;
    @(negedge clk);
    dmi_write = 1'b0;
  endtask

  task automatic dmi_rd(input logic [6:0] a, input logic [31:0] exp);
    exp_q.push_back(exp);
    dmi_addr = a; dmi_read = 1'b1;
    @(negedge clk);
    dmi_read = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((bus_read || bus_write) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("bus_done_bound", 1, 0);
    @(negedge clk);
  endtask

  // DMI read monitor
  initial begin
    logic pend;
    logic [31:0] e;
    forever begin
      @(posedge clk);
      pend = dmi_read && !rst;
      @(negedge clk);
      if (pend) begin
        if (exp_q.size() == 0) begin
          check("dmi_rdata_unexpected", {46'h0, dmi_rdata}, '1);
        end else begin
          e = exp_q.pop_front();
          check("dmi_rdata", {46'h0, dmi_rdata}, {46'h0, e});
        end
      end
    end
  end

  // bus transaction monitor: compares each request when it ends
  initial begin
    logic          in_req;
    logic [BW-9:0] cur;
    int            len;
    in_req = 1'b0; len = 0; cur = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        in_req = 1'b0;
        len = 0;
      end else if (bus_read || bus_write) begin
        if (!in_req) begin
          in_req = 1'b1;
          len = 1;
          cur = {bus_read, bus_write, bus_addr, bus_byteenable, (bus_read ? 32'h0 : bus_wdata)};
        end else begin
          len++;
        end
      end else if (in_req) begin
        in_req = 1'b0;
        if (bus_q.size() == 0) check("bus_unexpected", {cur, 8'(len)}, '0);
        else check("bus_txn", {cur, 8'(len)}, bus_q.pop_front());
      end
    end
  end

  // bus responder: acks on the ack_at-th request cycle (0 = never)
  initial begin
    int rcnt;
    rcnt = 0;
    bus_ack = 1'b0; bus_err = 1'b0; bus_rdata = '0;
    forever begin
      @(negedge clk);
      if (rst || !(bus_read || bus_write)) begin
        rcnt = 0;
        bus_ack = 1'b0;
        bus_err = 1'b0;
      end else begin
        rcnt++;
        bus_ack   = (rcnt == ack_at);
        bus_err   = (rcnt == ack_at) && resp_err;
        bus_rdata = mem[bus_addr[5:2]];
      end
    end
  end

  // main stimulus
  initial begin
    rst = 1'b1;
    dmi_addr = '0; dmi_wdata = '0; dmi_write = 1'b0; dmi_read = 1'b0;
    ack_at = 0; resp_err = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    repeat (3) @(negedge clk);
    check("rdata_reset", {46'h0, dmi_rdata}, '0);
    rst = 1'b0;
    @(negedge clk);

    // reset state and decode
    dmi_rd(7'h38, 32'h2004_0407);
    dmi_rd(7'h39, 32'h0);
    dmi_rd(7'h3C, 32'h0);
    dmi_rd(7'h10, 32'h0);
    dmi_addr = 7'h38; #1 check("hit_38", {77'h0, dmi_hit}, 1);
    dmi_addr = 7'h3A; #1 check("hit_3a", {77'h0, dmi_hit}, 0);
    dmi_addr = 7'h3C; #1 check("hit_3c", {77'h0, dmi_hit}, 1);
    @(negedge clk);

    // word read on address write, acked on the 4th request cycle
    mem[0] = 32'hDEAD_BEEF; ack_at = 4;
    dmi_wr(7'h38, 32'h0014_0000);
    bus_q.push_back(mk_bus(1, 0, 32'h1000, 4'b1111, 0, 4));
    dmi_wr(7'h39, 32'h1000);
    wait_done();
    dmi_rd(7'h3C, 32'hDEAD_BEEF);
    dmi_rd(7'h38, 32'h2014_0407);

    // byte writes with autoincrement
    ack_at = 2;
    dmi_wr(7'h38, 32'h0001_0000);
    dmi_wr(7'h39, 32'h2003);
    bus_q.push_back(mk_bus(0, 1, 32'h2000, 4'b1000, 32'hA5A5_A5A5, 2));
    dmi_wr(7'h3C, 32'hA5);
    wait_done();
    dmi_rd(7'h39, 32'h2004);
    bus_q.push_back(mk_bus(0, 1, 32'h2004, 4'b0001, 32'h5A5A_5A5A, 2));
    dmi_wr(7'h3C, 32'h5A);
    wait_done();
    dmi_rd(7'h39, 32'h2005);

    // alignment and size errors, starts blocked until W1C
    dmi_wr(7'h38, 32'h0002_0000);
    dmi_wr(7'h39, 32'h3001);
    dmi_wr(7'h3C, 32'h1234);
    repeat (3) @(negedge clk);
    dmi_rd(7'h38, 32'h2002_3407);
    dmi_wr(7'h39, 32'h3000);
    dmi_wr(7'h3C, 32'h5678);
    repeat (3) @(negedge clk);
    dmi_wr(7'h38, 32'h0002_7000);
    dmi_rd(7'h38, 32'h2002_0407);
    dmi_wr(7'h38, 32'h0006_0000);
    dmi_wr(7'h3C, 32'h1);
    repeat (3) @(negedge clk);
    dmi_rd(7'h38, 32'h2006_4407);
    dmi_wr(7'h38, 32'h0004_7000);
    dmi_rd(7'h38, 32'h2004_0407);

    // timeout, then an ack on the final cycle
    ack_at = 0;
    bus_q.push_back(mk_bus(0, 1, 32'h3000, 4'b1111, 32'hCAFE_F00D, 8));
    dmi_wr(7'h3C, 32'hCAFE_F00D);
    wait_done();
    dmi_rd(7'h38, 32'h2004_1407);
    dmi_wr(7'h38, 32'h0004_7000);
    ack_at = 8;
    bus_q.push_back(mk_bus(0, 1, 32'h3000, 4'b1111, 32'h1234_5678, 8));
    dmi_wr(7'h3C, 32'h1234_5678);
    wait_done();
    dmi_rd(7'h38, 32'h2004_0407);

    // busy violation then target error
    ack_at = 6; resp_err = 1'b1;
    dmi_wr(7'h39, 32'h40);
    bus_q.push_back(mk_bus(0, 1, 32'h40, 4'b1111, 32'hAA, 6));
    dmi_wr(7'h3C, 32'hAA);
    dmi_wr(7'h3C, 32'hBB);
    wait_done();
    resp_err = 1'b0;
    dmi_rd(7'h3C, 32'hAA);
    dmi_rd(7'h39, 32'h40);
    dmi_rd(7'h38, 32'h2044_2407);
    dmi_wr(7'h38, 32'h0044_7000);
    dmi_rd(7'h38, 32'h2004_0407);

    // readondata streaming
    mem[0] = 32'h1111_1111; mem[1] = 32'h2222_3333; mem[2] = 32'h4444_5555; mem[3] = 32'h6666_7777;
    ack_at = 2;
    dmi_wr(7'h38, 32'h0015_8000);
    bus_q.push_back(mk_bus(1, 0, 32'h0, 4'b1111, 0, 2));
    dmi_wr(7'h39, 32'h0);
    wait_done();
    for (int i = 0; i < 3; i++) begin
      bus_q.push_back(mk_bus(1, 0, 32'(4 * (i + 1)), 4'b1111, 0, 2));
      dmi_rd(7'h3C, mem[i]);
      wait_done();
    end
    dmi_rd(7'h39, 32'h10);
    dmi_rd(7'h38, 32'h2015_8407);

    // reset during an outstanding read
    ack_at = 0;
    dmi_wr(7'h39, 32'h100);
    @(negedge clk);
    check("req_before_rst", {77'h0, bus_read}, 1);
    #2 rst = 1'b1;
    #1 check("bus_read_rst", {77'h0, bus_read}, 0);
    check("rdata_rst", {46'h0, dmi_rdata}, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    dmi_rd(7'h38, 32'h2004_0407);
    dmi_rd(7'h39, 32'h0);
    dmi_rd(7'h3C, 32'h0);

    // final report
    repeat (4) @(negedge clk);
    check("exp_q_drained", 78'(exp_q.size()), 0);
    check("bus_q_drained", 78'(bus_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
